word_chunk_packer: RTL and testbench

WORD_CHUNK_PACKER -- requirements
Module: word_chunk_packer

---
 rtl/word_chunk_packer.sv | 126 ++++++++++++
 tb/tb_word_chunk_packer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_chunk_packer.sv
//------------------------------------------------------------------------------
// Module   : word_chunk_packer
// Brief    : Buffers a word stream in a circular FIFO and emits CHUNK-word groups,
//            with a flush path that emits a trailing partial group.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module word_chunk_packer #(
    parameter int DATA_W = 32,
    parameter int CHUNK  = 5,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHUNK*DATA_W-1:0]   out_data,
    output logic [3:0]                out_count,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] C_CHUNK_LVL = LW'(CHUNK);
    localparam logic [LW-1:0] C_DEPTH_LVL = LW'(DEPTH);

    typedef enum logic [0:0] {
        FILL    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_W-1:0]         mem_q [DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]             level_q, level_d;
    logic                      flush_pend_q, flush_pend_d;
    logic [CHUNK*DATA_W-1:0]   out_data_q, out_data_d;
    logic [3:0]                out_count_q, out_count_d;

    logic                      push;
    logic                      load_full;
    logic                      load_part;
    logic [LW-1:0]             pop_n;
    logic [CHUNK*DATA_W-1:0]   gather;

    assign in_ready  = (level_q < C_DEPTH_LVL);
    assign push      = in_valid && in_ready;
    assign load_full = (state_q == FILL) && (level_q >= C_CHUNK_LVL);
    assign load_part = (state_q == FILL) && !load_full && (level_q != '0) && flush_pend_q;
    assign pop_n     = load_full ? C_CHUNK_LVL : (load_part ? level_q : '0);

    // Lanes beyond the number of words being loaded read as zero.
    for (genvar k = 0; k < CHUNK; k++) begin : g_lane
        localparam logic [LW-1:0] C_K = LW'(k);
        assign gather[k*DATA_W +: DATA_W] = (C_K < pop_n) ? mem_q[rd_ptr_q + AW'(k)] : '0;
    end

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = rd_ptr_q + pop_n[AW-1:0];
        level_d      = level_q + LW'(push) - pop_n;

        case (state_q)
            FILL: begin
                if (load_full || load_part) begin
                    state_d     = PRESENT;
                    out_data_d  = gather;
                    out_count_d = 4'(pop_n);
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        // A pending flush is retired once the buffer is empty while filling,
        // which also covers a flush that arrives with nothing buffered.
        flush_pend_d = (flush || flush_pend_q) && !((state_q == FILL) && (level_d == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid = (state_q == PRESENT);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign level     = level_q;

endmodule

`default_nettype wire

// File: tb/tb_word_chunk_packer.sv
//------------------------------------------------------------------------------
// Module   : tb_word_chunk_packer
// Brief    : Directed and random stimulus for word_chunk_packer with an
//            in-order word scoreboard.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_word_chunk_packer;

    localparam int DW = 32;
    localparam int CH = 5;
    localparam int DP = 16;
    localparam int WB = CH * DW;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [WB-1:0]   out_data;
    logic [3:0]      out_count;
    logic [$clog2(DP):0] level;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    word_chunk_packer #(.DATA_W(DW), .CHUNK(CH), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane(input int k);
        return out_data[k*DW +: DW];
    endfunction

    // Words leave in arrival order; lanes past out_count must be zero.
    task automatic check_chunk();
        check("count_range", WB'((out_count >= 1) && (out_count <= CH)), WB'(1));
        for (int k = 0; k < CH; k++) begin
            if (k < int'(out_count)) begin
                check("sb_nonempty", WB'(exp_q.size() != 0), WB'(1));
                if (exp_q.size() != 0) check("lane_data", WB'(lane(k)), WB'(exp_q.pop_front()));
            end else begin
                check("lane_zero", WB'(lane(k)), '0);
            end
        end
    endtask

    task automatic tick();
        logic          pushing, popping, hold;
        logic [DW-1:0] pdata;
        logic [WB-1:0] prev_data;
        logic [3:0]    prev_cnt;
        pushing   = in_valid && in_ready && !rst;
        popping   = out_valid && out_ready && !rst;
        hold      = out_valid && !out_ready && !rst;
        pdata     = in_data;
        prev_data = out_data;
        prev_cnt  = out_count;
        if (popping) check_chunk();
        @(posedge clk);
        #1;
        if (pushing) exp_q.push_back(pdata);
        if (hold) begin
            check("hold_valid", WB'(out_valid), WB'(1));
            check("hold_data", out_data, prev_data);
            check("hold_count", WB'(out_count), WB'(prev_cnt));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && !out_valid; i++) tick();
        check(tag, WB'(out_valid), WB'(1));
    endtask

    task automatic drain(input string tag, input int budget);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < budget && (exp_q.size() != 0 || out_valid); i++) tick();
        check({tag, "_left"}, WB'(exp_q.size()), '0);
        check({tag, "_level"}, WB'(level), '0);
    endtask

    initial begin
        int n;
        int guard;
        logic acc;
        logic seen;

        // Reset state
        do_reset();
        check("rst_out_valid", WB'(out_valid), '0);
        check("rst_level", WB'(level), '0);
        check("rst_in_ready", WB'(in_ready), WB'(1));
        check("rst_out_count", WB'(out_count), '0);
        check("rst_out_data", out_data, '0);

        // Five consecutive pushes, chunk one cycle after the fifth
        out_ready = 1'b1;
        push_word(32'd1);
        check("first_push_level", WB'(level), WB'(1));
        for (int i = 2; i <= 5; i++) begin
            in_valid = 1'b1; in_data = DW'(i); tick();
        end
        in_valid = 1'b0;
        check("lat_not_yet", WB'(out_valid), '0);
        check("lat_level5", WB'(level), WB'(5));
        tick();
        check("lat_valid", WB'(out_valid), WB'(1));
        check("lat_count", WB'(out_count), WB'(5));
        for (int k = 0; k < CH; k++) check("lat_lane", WB'(lane(k)), WB'(k + 1));
        check("lat_level0", WB'(level), '0);
        tick();
        check("lat_release", WB'(out_valid), '0);

        // Seven words then flush: full chunk, then partial of two
        do_reset();
        for (int i = 10; i <= 16; i++) begin
            in_valid = 1'b1; in_data = DW'(i); tick();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_full_valid", WB'(out_valid), WB'(1));
        check("fl_full_count", WB'(out_count), WB'(5));
        check("fl_full_lane0", WB'(lane(0)), WB'(10));
        out_ready = 1'b1;
        tick();
        wait_valid("fl_part_valid", 4);
        check("fl_part_count", WB'(out_count), WB'(2));
        check("fl_part_lane1", WB'(lane(1)), WB'(16));
        check("fl_part_lane4", WB'(lane(4)), '0);
        tick();
        check("fl_level0", WB'(level), '0);
        push_word(32'd99);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("fl_pend_cleared", WB'(seen), '0);
        check("fl_single_level", WB'(level), WB'(1));
        drain("fl_drain", 20);

        // Back-pressure until the buffer is full
        do_reset();
        out_ready = 1'b0;
        n = 0;
        guard = 0;
        while (in_ready && guard < 60) begin
            in_valid = 1'b1; in_data = DW'(100 + n); tick();
            n++; guard++;
        end
        check("bp_accepted", WB'(n), WB'(DP + CH));
        check("bp_level", WB'(level), WB'(DP));
        check("bp_in_ready", WB'(in_ready), '0);
        check("bp_out_valid", WB'(out_valid), WB'(1));
        check("bp_lane0", WB'(lane(0)), WB'(100));
        in_data = 32'hdead;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        check("bp_level_hold", WB'(level), WB'(DP));
        drain("bp_drain", 100);

        // Flush with empty buffer emits nothing; next five form a full chunk
        do_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("ef_no_chunk", WB'(seen), '0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = DW'(200 + i); tick();
        end
        in_valid = 1'b0;
        wait_valid("ef_chunk_valid", 4);
        check("ef_chunk_count", WB'(out_count), WB'(5));
        tick();

        // Reset while presenting with three words buffered
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = DW'(300 + i); tick();
        end
        in_valid = 1'b0;
        check("mr_pre_valid", WB'(out_valid), WB'(1));
        check("mr_pre_level", WB'(level), WB'(3));
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        check("mr_out_valid", WB'(out_valid), '0);
        check("mr_level", WB'(level), '0);
        check("mr_in_ready", WB'(in_ready), WB'(1));
        check("mr_out_count", WB'(out_count), '0);

        // Random valid/ready/flush traffic
        n = 0;
        guard = 0;
        while (n < 10000 && guard < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = $urandom_range(0, 1);
            flush     = ($urandom_range(0, 63) == 0);
            acc = in_valid && in_ready;
            tick();
            if (acc) n++;
            guard++;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        check("rand_words", WB'(n), WB'(10000));
        drain("rand_drain", 300);
        check("rand_idle", WB'(out_valid), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
